// File: rtl/sram_stage_sequencer_pkg.sv
// Shared types and constants for the image-decoder stage sequencer.
package sram_stage_sequencer_pkg;

  // Sequencer states, in the order the decode pipeline walks through them.
  typedef enum logic [2:0] {
    S_SEQ_IDLE     = 3'd0,
    S_SEQ_UART     = 3'd1,
    S_SEQ_M2_START = 3'd2,
    S_SEQ_M2_WAIT  = 3'd3,
    S_SEQ_M1_START = 3'd4,
    S_SEQ_M1_WAIT  = 3'd5,
    S_SEQ_DISPLAY  = 3'd6,
    S_SEQ_ERROR    = 3'd7
  } seq_state_type;

  // SRAM bus owner encoding, also visible on the owner output.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_UART = 2'd1;
  localparam logic [1:0] OWN_M2   = 2'd2;
  localparam logic [1:0] OWN_M1   = 2'd3;

  // SRAM region base addresses of the decoded image layout.
  localparam logic [17:0] Y_BASE   = 18'd0;
  localparam logic [17:0] U_BASE   = 18'd38400;
  localparam logic [17:0] V_BASE   = 18'd57600;
  localparam logic [17:0] RGB_BASE = 18'd146944;

  // One SRAM request: address, write data and active-low write enable.
  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        we_n;
  } sram_req_t;

  // Which stage holds the SRAM port in a given state.
  function automatic logic [1:0] owner_of(input seq_state_type s);
    logic [1:0] o;
    o = OWN_NONE;
    case (s)
      S_SEQ_UART:                    o = OWN_UART;
      S_SEQ_M2_START, S_SEQ_M2_WAIT: o = OWN_M2;
      S_SEQ_M1_START, S_SEQ_M1_WAIT: o = OWN_M1;
      default:                       o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sram_stage_sequencer_if.sv
// Handshake and SRAM bus bundle between the sequencer and the stage modules.
interface sram_stage_sequencer_if;

  logic        go;
  logic        uart_active;
  logic        uart_done;
  logic [17:0] uart_addr;
  logic [15:0] uart_wdata;
  logic        uart_we_n;

  logic        m2_start;
  logic        m2_done;
  logic [17:0] m2_addr;
  logic [15:0] m2_wdata;
  logic        m2_we_n;

  logic        m1_start;
  logic        m1_done;
  logic [17:0] m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_we_n;

  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        vga_enable;
  logic [1:0]  owner;
  logic        busy;
  logic        error;

  // Sequencer side.
  modport master (
    input  go, uart_active, uart_done, uart_addr, uart_wdata, uart_we_n,
    input  m2_done, m2_addr, m2_wdata, m2_we_n,
    input  m1_done, m1_addr, m1_wdata, m1_we_n,
    output m2_start, m1_start,
    output SRAM_address, SRAM_write_data, SRAM_we_n,
    output vga_enable, owner, busy, error
  );

  // Stage / environment side.
  modport slave (
    output go, uart_active, uart_done, uart_addr, uart_wdata, uart_we_n,
    output m2_done, m2_addr, m2_wdata, m2_we_n,
    output m1_done, m1_addr, m1_wdata, m1_we_n,
    input  m2_start, m1_start,
    input  SRAM_address, SRAM_write_data, SRAM_we_n,
    input  vga_enable, owner, busy, error
  );

endinterface

// File: rtl/sram_stage_sequencer_sram_port_mux.sv
// Combinational owner-select mux for the single SRAM port; also used by the display path.
module sram_port_mux
  import sram_stage_sequencer_pkg::*;
#(
  parameter logic [17:0] DEFAULT_ADDR = 18'd0
) (
  input  logic [1:0] owner,
  input  sram_req_t  uart_req,
  input  sram_req_t  m2_req,
  input  sram_req_t  m1_req,
  output sram_req_t  sram_req
);

  // Pass through only the owning stage; everyone else is shut out, including its we_n.
  always_comb begin
    // NOTE: idle value is assigned before the case so no path leaves sram_req unassigned (no latch).
    sram_req = '{addr: DEFAULT_ADDR, wdata: 16'd0, we_n: 1'b1};
    case (owner)
      OWN_UART: sram_req = uart_req;
      OWN_M2:   sram_req = m2_req;
      OWN_M1:   sram_req = m1_req;
      default:  ;
    endcase
  end

endmodule

// File: rtl/sram_stage_sequencer.sv
// Top-level decode scheduler: UART load -> M2 -> M1 -> VGA display, owning the SRAM port.
module sram_stage_sequencer
  import sram_stage_sequencer_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000,
  parameter logic [17:0] DEFAULT_ADDR   = 18'd0
) (
  input logic                    CLOCK_50_I,
  input logic                    resetn,
  sram_stage_sequencer_if.master bus
);

  seq_state_type state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          m2_start_q, m2_start_d;
  logic          m1_start_q, m1_start_d;
  logic          vga_enable_q, vga_enable_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic          go_q, go_d;
  logic [23:0]   wd_q, wd_d;

  logic          go_rise;
  logic          stage_done;
  logic          wd_counting;
  logic          timeout;
  logic          unused_uart_active;

  sram_req_t     uart_req, m2_req, m1_req, sram_req;

  // The loader's activity flag is informational; the UART stage exits on uart_done alone.
  assign unused_uart_active = bus.uart_active;

  assign go_d    = bus.go;
  assign go_rise = bus.go & ~go_q;

  // Select the done flag of the stage being waited on and whether the watchdog runs.
  always_comb begin
    stage_done  = 1'b0;
    wd_counting = 1'b0;
    case (state_q)
      S_SEQ_UART: begin
        stage_done  = bus.uart_done;
        wd_counting = 1'b1;
      end
      S_SEQ_M2_WAIT: begin
        stage_done  = bus.m2_done;
        wd_counting = 1'b1;
      end
      S_SEQ_M1_WAIT: begin
        stage_done  = bus.m1_done;
        wd_counting = 1'b1;
      end
      default: ;
    endcase
  end

  // A zero limit disables the watchdog entirely.
  assign timeout = wd_counting && (TIMEOUT_CYCLES != 24'd0) &&
                   (wd_q == TIMEOUT_CYCLES - 24'd1);

  // Next-state logic; a stage's done takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEQ_IDLE:     if (bus.go) state_d = S_SEQ_UART;
      S_SEQ_UART: begin
        if (stage_done)   state_d = S_SEQ_M2_START;
        else if (timeout) state_d = S_SEQ_ERROR;
      end
      // A done left high from the previous frame is ignored in the START states.
      S_SEQ_M2_START: state_d = S_SEQ_M2_WAIT;
      S_SEQ_M2_WAIT: begin
        if (stage_done)   state_d = S_SEQ_M1_START;
        else if (timeout) state_d = S_SEQ_ERROR;
      end
      S_SEQ_M1_START: state_d = S_SEQ_M1_WAIT;
      S_SEQ_M1_WAIT: begin
        if (stage_done)   state_d = S_SEQ_DISPLAY;
        else if (timeout) state_d = S_SEQ_ERROR;
      end
      S_SEQ_DISPLAY:  if (go_rise) state_d = S_SEQ_UART;
      S_SEQ_ERROR:    if (go_rise) state_d = S_SEQ_IDLE;
      default:        state_d = S_SEQ_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    owner_d      = owner_of(state_d);
    m2_start_d   = (state_d == S_SEQ_M2_START);
    m1_start_d   = (state_d == S_SEQ_M1_START);
    vga_enable_d = (state_d == S_SEQ_DISPLAY);
    error_d      = (state_d == S_SEQ_ERROR);
    busy_d       = !((state_d == S_SEQ_IDLE) || (state_d == S_SEQ_DISPLAY) ||
                     (state_d == S_SEQ_ERROR));
    wd_d         = wd_q;
    if (state_d != state_q) begin
      wd_d = 24'd0;
    end else if (wd_counting && (TIMEOUT_CYCLES != 24'd0)) begin
      wd_d = wd_q + 24'd1;
    end
  end

  // State and output registers; reset parks the port with no owner at once.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_SEQ_IDLE;
      owner_q      <= OWN_NONE;
      m2_start_q   <= 1'b0;
      m1_start_q   <= 1'b0;
      vga_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      go_q         <= 1'b0;
      wd_q         <= 24'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      m2_start_q   <= m2_start_d;
      m1_start_q   <= m1_start_d;
      vga_enable_q <= vga_enable_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      go_q         <= go_d;
      wd_q         <= wd_d;
    end
  end

  assign uart_req = '{addr: bus.uart_addr, wdata: bus.uart_wdata, we_n: bus.uart_we_n};
  assign m2_req   = '{addr: bus.m2_addr,   wdata: bus.m2_wdata,   we_n: bus.m2_we_n};
  assign m1_req   = '{addr: bus.m1_addr,   wdata: bus.m1_wdata,   we_n: bus.m1_we_n};

  sram_port_mux #(
    .DEFAULT_ADDR (DEFAULT_ADDR)
  ) u_mux (
    .owner    (owner_q),
    .uart_req (uart_req),
    .m2_req   (m2_req),
    .m1_req   (m1_req),
    .sram_req (sram_req)
  );

  assign bus.SRAM_address    = sram_req.addr;
  assign bus.SRAM_write_data = sram_req.wdata;
  // Writes are blocked outright while latched in ERROR.
  assign bus.SRAM_we_n       = sram_req.we_n | error_q;

  assign bus.owner      = owner_q;
  assign bus.m2_start   = m2_start_q;
  assign bus.m1_start   = m1_start_q;
  assign bus.vga_enable = vga_enable_q;
  assign bus.busy       = busy_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Self-checking bench for sram_stage_sequencer: stimulus tables with a scoreboard queue.
module tb_sram_stage_sequencer;
  import sram_stage_sequencer_pkg::*;

  localparam logic [17:0] DEF_ADDR = 18'h1_2345;
  localparam logic [17:0] U_ADDR   = 18'h0_0111;
  localparam logic [17:0] M2_ADDR  = 18'h0_0222;
  localparam logic [15:0] U_DATA   = 16'hAAAA;
  localparam logic [15:0] M2_DATA  = 16'hBBBB;
  localparam logic [15:0] M1_DATA  = 16'hCCCC;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  sram_stage_sequencer_if bus ();

  sram_stage_sequencer #(
    .TIMEOUT_CYCLES (24'd16),
    .DEFAULT_ADDR   (DEF_ADDR)
  ) dut (
    .CLOCK_50_I (clk),
    .resetn     (resetn),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // One stimulus row: inputs held for rep cycles, outputs expected after each edge.
  typedef struct {
    int         rep;
    logic       go, ud, m2d, m1d;
    logic       uwe, m2we, m1we;
    logic [1:0] own;
    logic       m2s, m1s, vga, busy, err;
  } row_t;

  typedef struct {
    string       tag;
    logic [1:0]  own;
    logic [4:0]  flags;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        we_n;
  } exp_t;

  row_t tab_a[$];
  row_t tab_b[$];
  exp_t exp_q[$];

  function automatic row_t mk(input int rep, input logic go, ud, m2d, m1d,
                              input logic uwe, m2we, m1we, input logic [1:0] own,
                              input logic m2s, m1s, vga, busy, err);
    row_t r;
    r.rep = rep; r.go = go; r.ud = ud; r.m2d = m2d; r.m1d = m1d;
    r.uwe = uwe; r.m2we = m2we; r.m1we = m1we; r.own = own;
    r.m2s = m2s; r.m1s = m1s; r.vga = vga; r.busy = busy; r.err = err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Expected SRAM port for a given owner and the current stage requests.
  function automatic exp_t expect_of(input row_t r, input string tag);
    exp_t e;
    e.tag   = tag;
    e.own   = r.own;
    e.flags = {r.m2s, r.m1s, r.vga, r.busy, r.err};
    case (r.own)
      2'd1:    begin e.addr = U_ADDR;   e.wdata = U_DATA;  e.we_n = r.uwe;  end
      2'd2:    begin e.addr = M2_ADDR;  e.wdata = M2_DATA; e.we_n = r.m2we; end
      2'd3:    begin e.addr = RGB_BASE; e.wdata = M1_DATA; e.we_n = r.m1we; end
      default: begin e.addr = DEF_ADDR; e.wdata = 16'd0;   e.we_n = 1'b1;   end
    endcase
    return e;
  endfunction

  task automatic compare_front();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, "_owner"}, {30'd0, bus.owner}, {30'd0, e.own});
    check({e.tag, "_flags(m2s,m1s,vga,busy,err)"},
          {27'd0, bus.m2_start, bus.m1_start, bus.vga_enable, bus.busy, bus.error},
          {27'd0, e.flags});
    check({e.tag, "_addr"}, {14'd0, bus.SRAM_address}, {14'd0, e.addr});
    check({e.tag, "_wdata"}, {16'd0, bus.SRAM_write_data}, {16'd0, e.wdata});
    check({e.tag, "_we_n"}, {31'd0, bus.SRAM_we_n}, {31'd0, e.we_n});
  endtask

  task automatic apply_row(input row_t r, input string tag);
    for (int k = 0; k < r.rep; k++) begin
      @(negedge clk);
      bus.go = r.go;  bus.uart_done = r.ud; bus.m2_done = r.m2d; bus.m1_done = r.m1d;
      bus.uart_we_n = r.uwe; bus.m2_we_n = r.m2we; bus.m1_we_n = r.m1we;
      exp_q.push_back(expect_of(r, $sformatf("%s.%0d", tag, k)));
      @(posedge clk);
      #1;
      compare_front();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.go = 1'b0; bus.uart_active = 1'b1; bus.uart_done = 1'b0;
    bus.m2_done = 1'b0; bus.m1_done = 1'b0;
    bus.uart_addr = U_ADDR;   bus.uart_wdata = U_DATA;  bus.uart_we_n = 1'b0;
    bus.m2_addr   = M2_ADDR;  bus.m2_wdata   = M2_DATA; bus.m2_we_n   = 1'b0;
    bus.m1_addr   = RGB_BASE; bus.m1_wdata   = M1_DATA; bus.m1_we_n   = 1'b0;

    // Main pass, stale/spurious dones, timeout, error recovery, done-vs-timeout tie.
    //                rep go ud m2 m1 uwe m2we m1we own m2s m1s vga busy err
    tab_a.push_back(mk( 1, 1, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 9, 0, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 1, 1, 0, 0, 1, 0, 2'd2, 1, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 1, 1, 0, 0, 1, 0, 2'd2, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 4, 0, 1, 0, 1, 0, 0, 0, 2'd2, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 0, 1, 1, 1, 1, 0, 2'd3, 0, 1, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 0, 1, 1, 1, 1, 0, 2'd3, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 4, 0, 0, 1, 0, 1, 1, 0, 2'd3, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 0, 1, 1, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0));
    tab_a.push_back(mk( 3, 0, 0, 1, 1, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0));
    tab_a.push_back(mk( 1, 1, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 2, 1, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 1, 0, 0, 0, 1, 1, 2'd2, 1, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 1, 0, 0, 0, 1, 1, 2'd2, 0, 0, 0, 1, 0));
    tab_a.push_back(mk(15, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
    tab_a.push_back(mk( 2, 0, 0, 1, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
    tab_a.push_back(mk( 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    tab_a.push_back(mk( 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    tab_a.push_back(mk( 1, 1, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0, 0, 1, 0));
    tab_a.push_back(mk(15, 0, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 1, 0, 0, 0, 1, 1, 2'd2, 1, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 1, 0, 0, 0, 1, 1, 2'd2, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 0, 1, 0, 0, 1, 1, 2'd3, 0, 1, 0, 1, 0));
    tab_a.push_back(mk( 1, 0, 0, 1, 0, 0, 1, 1, 2'd3, 0, 0, 0, 1, 0));
    tab_a.push_back(mk( 2, 0, 0, 0, 0, 1, 1, 0, 2'd3, 0, 0, 0, 1, 0));

    // After reset: instant dones with go held high, then a fresh go edge in DISPLAY.
    tab_b.push_back(mk( 1, 1, 1, 1, 1, 0, 1, 1, 2'd1, 0, 0, 0, 1, 0));
    tab_b.push_back(mk( 1, 1, 1, 1, 1, 0, 1, 1, 2'd2, 1, 0, 0, 1, 0));
    tab_b.push_back(mk( 1, 1, 1, 1, 1, 0, 1, 1, 2'd2, 0, 0, 0, 1, 0));
    tab_b.push_back(mk( 1, 1, 1, 1, 1, 0, 1, 1, 2'd3, 0, 1, 0, 1, 0));
    tab_b.push_back(mk( 1, 1, 1, 1, 1, 0, 1, 1, 2'd3, 0, 0, 0, 1, 0));
    tab_b.push_back(mk( 1, 1, 1, 1, 1, 0, 1, 1, 2'd0, 0, 0, 1, 0, 0));
    tab_b.push_back(mk( 2, 1, 1, 1, 1, 0, 1, 1, 2'd0, 0, 0, 1, 0, 0));
    tab_b.push_back(mk( 1, 0, 1, 1, 1, 0, 1, 1, 2'd0, 0, 0, 1, 0, 0));
    tab_b.push_back(mk( 1, 1, 0, 0, 0, 0, 1, 1, 2'd1, 0, 0, 0, 1, 0));

    // Reset values appear before any clock edge.
    #2;
    check("rst0_owner", {30'd0, bus.owner}, 32'd0);
    check("rst0_flags", {27'd0, bus.m2_start, bus.m1_start, bus.vga_enable, bus.busy, bus.error}, 32'd0);
    check("rst0_addr",  {14'd0, bus.SRAM_address}, {14'd0, DEF_ADDR});
    check("rst0_wdata", {16'd0, bus.SRAM_write_data}, 32'd0);
    check("rst0_we_n",  {31'd0, bus.SRAM_we_n}, 32'd1);

    @(negedge clk);
    resetn = 1'b1;

    foreach (tab_a[i]) apply_row(tab_a[i], $sformatf("a%0d", i));

    // Reset asserted mid-M1_WAIT while M1 is writing: port must release without a clock.
    @(negedge clk);
    bus.m1_we_n = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_we_n",     {31'd0, bus.SRAM_we_n}, 32'd1);
    check("midrst_owner",    {30'd0, bus.owner}, 32'd0);
    check("midrst_m1_start", {31'd0, bus.m1_start}, 32'd0);
    check("midrst_addr",     {14'd0, bus.SRAM_address}, {14'd0, DEF_ADDR});
    check("midrst_busy",     {31'd0, bus.busy}, 32'd0);

    bus.go = 1'b0; bus.uart_done = 1'b0; bus.m2_done = 1'b0; bus.m1_done = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    foreach (tab_b[i]) apply_row(tab_b[i], $sformatf("b%0d", i));

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
